mod_mul_serial: RTL and testbench

//  Sequential bit-serial (radix-2, MSB-first interleaved) modular multiplier: r = (a*b) mod p.

---
 rtl/mod_arith_pkg.sv | 28 ++
 rtl/mod_red_step.sv | 48 ++++
 rtl/mod_mul_serial.sv | 130 +++++++++++++
 tb/tb_mod_mul_serial.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// ---------------------------------------------------------------------------
// mod_arith_pkg
// Shared definitions for the modular-arithmetic datapath:
//   - default operand width and iteration-counter width
//   - state encoding of the serial multiplier FSM
//   - operand/result mux select codes (the multiplier feeds INS_MUL)
// ---------------------------------------------------------------------------
package mod_arith_pkg;

  localparam int MA_WIDTH = 89;
  localparam int MA_CNT_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  typedef enum logic [2:0] {
    INS_NOP = 3'd0,
    INS_DIN = 3'd1,
    INS_MEM = 3'd2,
    INS_ADD = 3'd3,
    INS_SUB = 3'd4,
    INS_MUL = 3'd5
  } ins_t;

endpackage

// File: rtl/mod_red_step.sv
// ---------------------------------------------------------------------------
// mod_red_step
// One combinational iteration of the MSB-first interleaved modular multiply:
//   t = 2*acc + (bit ? b : 0);  then up to two conditional subtractions of p.
// With acc < p and b < p the sum is below 3p, so two subtractions always
// bring it back into [0, p).
// Ports:
//   i_acc  in  WIDTH  running accumulator (< p)
//   i_bit  in  1      current multiplicand bit
//   i_b    in  WIDTH  multiplier
//   i_p    in  WIDTH  modulus
//   o_t    out WIDTH  reduced accumulator for the next iteration
// ---------------------------------------------------------------------------
module mod_red_step #(
  parameter int WIDTH = 89
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_p,
  output logic [WIDTH-1:0] o_t
);

  localparam int XW = WIDTH + 2;

  function automatic logic [XW-1:0] cond_sub(input logic [XW-1:0] x,
                                             input logic [XW-1:0] m);
    cond_sub = (x >= m) ? (x - m) : x;
  endfunction

  logic [XW-1:0] w_p_ext;
  logic [XW-1:0] w_addend;
  logic [XW-1:0] w_sum;
  logic [XW-1:0] w_sub1;
  logic [XW-1:0] w_sub2;
  logic [1:0]    w_unused_hi;

  assign w_p_ext  = {2'b00, i_p};
  assign w_addend = i_bit ? {2'b00, i_b} : '0;
  assign w_sum    = {1'b0, i_acc, 1'b0} + w_addend;
  assign w_sub1   = cond_sub(w_sum, w_p_ext);
  assign w_sub2   = cond_sub(w_sub1, w_p_ext);

  // After the second subtraction the value is below p, so the two extra
  // guard bits are zero for in-contract operands and can be dropped.
  assign {w_unused_hi, o_t} = w_sub2;

endmodule

// File: rtl/mod_mul_serial.sv
// ---------------------------------------------------------------------------
// mod_mul_serial
// Bit-serial radix-2 modular multiplier, result = (a*b) mod p.
// One multiplicand bit (MSB first) is consumed per clock; WIDTH clocks per
// operation. The result drives the INS_MUL input of the operand/result mux.
// Ports:
//   clk     in  1      rising-edge clock
//   rst     in  1      asynchronous active-high reset
//   start   in  1      operation request, only honoured in IDLE
//   a       in  WIDTH  multiplicand (a < p)
//   b       in  WIDTH  multiplier   (b < p)
//   p       in  WIDTH  odd modulus, p > 2
//   busy    out 1      high for the WIDTH cycles of RUN
//   done    out 1      single-cycle pulse, result valid
//   result  out WIDTH  product mod p, held until the next completed operation
// ---------------------------------------------------------------------------
module mod_mul_serial
  import mod_arith_pkg::*;
#(
  parameter int WIDTH = MA_WIDTH,
  parameter int CNT_W = MA_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  mul_state_t       r_state;
  mul_state_t       w_state_nxt;
  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;

  logic             w_bit;
  logic [WIDTH-1:0] w_t;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_bit = r_a[r_cnt];

  mod_red_step #(
    .WIDTH (WIDTH)
  ) u_red_step (
    .i_acc (r_acc),
    .i_bit (w_bit),
    .i_b   (r_b),
    .i_p   (r_p),
    .o_t   (w_t)
  );

  // Operand capture, iteration and result update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_p      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_load) begin
      r_a   <= a;
      r_b   <= b;
      r_p   <= p;
      r_acc <= '0;
      r_cnt <= CNT_W'(WIDTH - 1);
    end else if (w_step) begin
      r_acc <= w_t;
      // Counter parks at zero after the last bit instead of wrapping.
      if (w_last) begin
        r_result <= w_t;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mod_mul_serial.sv
module tb_mod_mul_serial;
  import mod_arith_pkg::*;

  localparam int W = MA_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_mul_serial #(
    .WIDTH (W),
    .CNT_W (MA_CNT_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .p      (p),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    logic [95:0] x;
    x = {$urandom(), $urandom(), $urandom()};
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] rem;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    rem  = prod % {{W{1'b0}}, m};
    return rem[W-1:0];
  endfunction

  // Called at a falling edge while the DUT is idle; returns at a falling
  // edge in the IDLE cycle that follows the done pulse.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [W-1:0] tp, input logic [W-1:0] exp,
                        input string tag, input bit inject);
    logic [W-1:0] prev;
    int n;
    int nbusy;
    prev  = result;
    a     = ta;
    b     = tb;
    p     = tp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = rnd_w();
    b     = rnd_w();
    p     = rnd_w();
    n     = 0;
    nbusy = 0;
    while (!done && n < W + 20) begin
      if (busy) nbusy++;
      if (n == W / 2) chk({tag, "_hold"}, result, prev);
      if (inject && (n == 1 || n == 40)) begin
        start = 1'b1;
        a     = 2;
        b     = 3;
        p     = 7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, n, W);
    chk({tag, "_busycycles"}, nbusy, W);
    chk({tag, "_busy_at_done"}, busy, 1'b0);
    chk({tag, "_result"}, result, exp);
    if (inject) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_width"}, done, 1'b0);
    if (inject) chk({tag, "_start_in_done_ignored"}, busy, 1'b0);
    chk({tag, "_result_held"}, result, exp);
  endtask

  initial begin
    logic [W-1:0] m;
    logic [W-1:0] two88;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rp;
    int ndone;

    m     = {W{1'b1}};
    two88 = '0;
    two88[W-1] = 1'b1;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    p     = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_result", result, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    run_op('0, 5, m, '0, "zero_a", 1'b0);
    run_op(1, m - 1, m, m - 1, "one_times_pm1", 1'b0);
    run_op(m - 1, m - 1, m, 1, "pm1_squared", 1'b0);
    run_op(two88, 2, m, 1, "two_pow_89", 1'b0);
    run_op(3, 7, 5, 1, "small_3x7_mod5", 1'b0);
    run_op(10, 10, 7, 2, "small_10x10_mod7", 1'b0);

    for (int i = 0; i < 100; i++) begin
      rp    = rnd_w();
      rp[W-1] = 1'b0;
      rp[0] = 1'b1;
      if (rp < 3) rp = 3;
      ra = rnd_w() % rp;
      rb = rnd_w() % rp;
      run_op(ra, rb, rp, ref_mulmod(ra, rb, rp), $sformatf("rand%0d", i), 1'b0);
    end

    // Extra start pulses in RUN and DONE are ignored; IDLE start accepted.
    run_op(6, 9, 11, 10, "inject_6x9_mod11", 1'b1);
    run_op(4, 6, 11, 2, "after_inject_4x6_mod11", 1'b0);

    // Asynchronous abort in the middle of an operation.
    a     = 5;
    b     = 5;
    p     = 13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle_busy", busy, 1'b0);
    run_op(5, 5, 13, 12, "post_abort_5x5_mod13", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
